// File: rtl/uart_regbank_if.sv
// Processor-side bus for uart_regbank.
//   addr       word address
//   we / re    single-cycle write / read requests
//   be         write byte enables, be[i] covers write_data[8i+7:8i]
//   write_data write data
//   read_data  registered read data, valid while rvalid is high
//   rvalid     read data valid
//   err        one-cycle pulse after an access to an unmapped address
interface uart_regbank_if #(
  parameter int unsigned ADDR_W = 22
);
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic              re;
  logic [3:0]        be;
  logic [31:0]       write_data;
  logic [31:0]       read_data;
  logic              rvalid;
  logic              err;

  modport master (
    output addr, we, re, be, write_data,
    input  read_data, rvalid, err
  );

  modport slave (
    input  addr, we, re, be, write_data,
    output read_data, rvalid, err
  );
endinterface

// File: rtl/uart_regbank.sv
// Register bank for a multi-channel UART subsystem.
// Per channel: CR (RW, two self-clearing reset bits), SR (RO), TDR (RW), RDR (RO).
// Global: IER (RW), IPR (read / write-1-to-clear, set on irq_src rising edge), ID (RO).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         processor bus (slave side of uart_regbank_if)
//   cr, tdr     channel config / transmit-data registers, channel k at [32k+31:32k]
//   sr, rdr     channel status / receive words
//   tx_write    one-cycle strobe after a TDR write, aligned with the new tdr value
//   rx_read     one-cycle strobe after an RDR read, aligned with rvalid
//   sr_read     one-cycle strobe after an SR read, aligned with rvalid
//   irq_src     per-channel interrupt source levels
//   irq         |(IER & IPR)
module uart_regbank #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned ADDR_W     = 22,
  parameter logic [31:0] CR_INIT    = 32'h0000c000,
  parameter int unsigned RX_RST_BIT = 0,
  parameter int unsigned TX_RST_BIT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_regbank_if.slave      bus,
  output logic [32*NCH-1:0]  cr,
  output logic [32*NCH-1:0]  tdr,
  input  logic [32*NCH-1:0]  sr,
  input  logic [32*NCH-1:0]  rdr,
  output logic [NCH-1:0]     tx_write,
  output logic [NCH-1:0]     rx_read,
  output logic [NCH-1:0]     sr_read,
  input  logic [NCH-1:0]     irq_src,
  output logic               irq
);

  localparam logic [ADDR_W-1:0] IerAddr     = ADDR_W'(4 * NCH);
  localparam logic [ADDR_W-1:0] IprAddr     = ADDR_W'(4 * NCH + 1);
  localparam logic [ADDR_W-1:0] IdAddr      = ADDR_W'(4 * NCH + 2);
  localparam logic [31:0]       IdValue     = 32'h55520000 | 32'(NCH);
  localparam logic [31:0]       SelfClrMask = (32'd1 << RX_RST_BIT) | (32'd1 << TX_RST_BIT);

  function automatic logic [31:0] merge_bytes(logic [31:0] old_val, logic [31:0] new_val,
                                              logic [3:0] en);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // State
  logic [NCH-1:0][31:0] cr_q, cr_d;
  logic [NCH-1:0][31:0] tdr_q, tdr_d;
  logic [NCH-1:0]       ier_q, ier_d;
  logic [NCH-1:0]       ipr_q, ipr_d;
  logic [NCH-1:0]       src_q;
  logic [31:0]          read_data_q, read_data_d;
  logic                 rvalid_q, err_q, err_d;
  logic [NCH-1:0]       tx_write_q, tx_write_d;
  logic [NCH-1:0]       rx_read_q, rx_read_d;
  logic [NCH-1:0]       sr_read_q, sr_read_d;

  // Address decode
  logic [NCH-1:0] ch_hit;
  logic [1:0]     reg_sel;
  logic           ier_hit, ipr_hit, id_hit, mapped;

  always_comb begin
    ch_hit = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_hit[k] = (bus.addr[ADDR_W-1:2] == (ADDR_W-2)'(k));
    end
    reg_sel = bus.addr[1:0];
    ier_hit = (bus.addr == IerAddr);
    ipr_hit = (bus.addr == IprAddr);
    id_hit  = (bus.addr == IdAddr);
    mapped  = (|ch_hit) | ier_hit | ipr_hit | id_hit;
  end

  // Register next state
  logic [31:0] ier_merged;
  logic [31:0] ipr_clr;

  always_comb begin
    cr_d  = cr_q;
    tdr_d = tdr_q;
    ier_d = ier_q;
    for (int k = 0; k < NCH; k++) begin
      // Reset bits drop after one cycle; a write in the same cycle overrides the clear.
      cr_d[k] = cr_q[k] & ~SelfClrMask;
      if (bus.we && ch_hit[k] && (reg_sel == 2'd0)) begin
        cr_d[k] = merge_bytes(cr_d[k], bus.write_data, bus.be);
      end
      if (bus.we && ch_hit[k] && (reg_sel == 2'd2)) begin
        tdr_d[k] = merge_bytes(tdr_q[k], bus.write_data, bus.be);
      end
    end

    ier_merged = merge_bytes(32'(ier_q), bus.write_data, bus.be);
    if (bus.we && ier_hit) ier_d = ier_merged[NCH-1:0];

    // Write-1-to-clear honours be[0]/be[1]; a same-cycle rising edge wins over the clear.
    ipr_clr = '0;
    if (bus.we && ipr_hit) begin
      ipr_clr = bus.write_data & {16'h0000, {8{bus.be[1]}}, {8{bus.be[0]}}};
    end
    ipr_d = (ipr_q & ~ipr_clr[NCH-1:0]) | (irq_src & ~src_q);
  end

  // Read mux, error and strobes; all sampled from pre-write values
  always_comb begin
    read_data_d = read_data_q;
    if (bus.re) begin
      read_data_d = '0;
      for (int k = 0; k < NCH; k++) begin
        if (ch_hit[k]) begin
          unique case (reg_sel)
            2'd0:    read_data_d = cr_q[k];
            2'd1:    read_data_d = sr[32*k +: 32];
            2'd2:    read_data_d = tdr_q[k];
            default: read_data_d = rdr[32*k +: 32];
          endcase
        end
      end
      if (ier_hit) read_data_d = 32'(ier_q);
      if (ipr_hit) read_data_d = 32'(ipr_q);
      if (id_hit)  read_data_d = IdValue;
    end

    err_d = (bus.we | bus.re) & ~mapped;

    for (int k = 0; k < NCH; k++) begin
      tx_write_d[k] = bus.we & ch_hit[k] & (reg_sel == 2'd2);
      rx_read_d[k]  = bus.re & ch_hit[k] & (reg_sel == 2'd3);
      sr_read_d[k]  = bus.re & ch_hit[k] & (reg_sel == 2'd1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q        <= {NCH{CR_INIT}};
      tdr_q       <= '0;
      ier_q       <= '0;
      ipr_q       <= '0;
      src_q       <= '0;
      read_data_q <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      tx_write_q  <= '0;
      rx_read_q   <= '0;
      sr_read_q   <= '0;
    end else begin
      cr_q        <= cr_d;
      tdr_q       <= tdr_d;
      ier_q       <= ier_d;
      ipr_q       <= ipr_d;
      src_q       <= irq_src;
      read_data_q <= read_data_d;
      rvalid_q    <= bus.re;
      err_q       <= err_d;
      tx_write_q  <= tx_write_d;
      rx_read_q   <= rx_read_d;
      sr_read_q   <= sr_read_d;
    end
  end

  assign cr            = cr_q;
  assign tdr           = tdr_q;
  assign tx_write      = tx_write_q;
  assign rx_read       = rx_read_q;
  assign sr_read       = sr_read_q;
  assign irq           = |(ier_q & ipr_q);
  assign bus.read_data = read_data_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_uart_regbank.sv
// Self-checking bench for uart_regbank: directed scenarios plus randomized traffic,
// all checked against a behavioural model of the register map.
module tb_uart_regbank;
  localparam int unsigned NCH     = 4;
  localparam int unsigned ADDR_W  = 22;
  localparam logic [31:0] CR_INIT = 32'h0000c000;
  localparam int          NREG    = 4 * NCH;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_regbank_if #(.ADDR_W(ADDR_W)) bus_if ();

  logic [NCH-1:0][31:0] cr_p, tdr_p, sr_p, rdr_p;
  logic [NCH-1:0]       tx_write, rx_read, sr_read, irq_src;
  logic                 irq;

  uart_regbank #(
    .NCH       (NCH),
    .ADDR_W    (ADDR_W),
    .CR_INIT   (CR_INIT),
    .RX_RST_BIT(0),
    .TX_RST_BIT(1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if),
    .cr      (cr_p),
    .tdr     (tdr_p),
    .sr      (sr_p),
    .rdr     (rdr_p),
    .tx_write(tx_write),
    .rx_read (rx_read),
    .sr_read (sr_read),
    .irq_src (irq_src),
    .irq     (irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  logic [31:0]    cr_m  [NCH];
  logic [31:0]    tdr_m [NCH];
  logic [NCH-1:0] ier_m, ipr_m, src_m;

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      cr_m[k]  = CR_INIT;
      tdr_m[k] = '0;
    end
    ier_m = '0;
    ipr_m = '0;
    src_m = '0;
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] old_val, input logic [31:0] new_val,
                                           input logic [3:0] en);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++) if (en[b]) r[8*b +: 8] = new_val[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    if (a < NREG) begin
      case (a % 4)
        0:       return cr_m[a/4];
        1:       return sr_p[a/4];
        2:       return tdr_m[a/4];
        default: return rdr_p[a/4];
      endcase
    end
    if (a == NREG)     return 32'(ier_m);
    if (a == NREG + 1) return 32'(ipr_m);
    if (a == NREG + 2) return 32'h55520000 | 32'(NCH);
    return 32'h0;
  endfunction

  task automatic bus_idle();
    bus_if.we         = 1'b0;
    bus_if.re         = 1'b0;
    bus_if.addr       = '0;
    bus_if.be         = '0;
    bus_if.write_data = '0;
  endtask

  // One bus cycle: drive, predict, clock, compare everything.
  task automatic step(input logic wr, input logic rd, input int a, input logic [3:0] be,
                      input logic [31:0] wd);
    logic [31:0]    exp_rd, tmp, clr;
    logic           exp_err;
    logic [NCH-1:0] exp_tx, exp_rx, exp_sr;
    bus_if.we         = wr;
    bus_if.re         = rd;
    bus_if.addr       = ADDR_W'(a);
    bus_if.be         = be;
    bus_if.write_data = wd;

    exp_rd  = model_read(a);
    exp_err = (wr || rd) && (a > NREG + 2);
    exp_tx  = '0;
    exp_rx  = '0;
    exp_sr  = '0;
    if (a < NREG) begin
      case (a % 4)
        1:       exp_sr[a/4] = rd;
        2:       exp_tx[a/4] = wr;
        3:       exp_rx[a/4] = rd;
        default: ;
      endcase
    end

    for (int k = 0; k < NCH; k++) cr_m[k] = cr_m[k] & ~32'h3;
    if (wr && a < NREG && (a % 4) == 0) cr_m[a/4]  = apply_be(cr_m[a/4], wd, be);
    if (wr && a < NREG && (a % 4) == 2) tdr_m[a/4] = apply_be(tdr_m[a/4], wd, be);
    if (wr && a == NREG) begin
      tmp   = apply_be(32'(ier_m), wd, be);
      ier_m = tmp[NCH-1:0];
    end
    clr = '0;
    if (wr && a == NREG + 1) begin
      clr = wd;
      if (!be[0]) clr[7:0] = '0;
      if (!be[1]) clr[15:8] = '0;
      clr[31:16] = '0;
    end
    ipr_m = (ipr_m & ~clr[NCH-1:0]) | (irq_src & ~src_m);
    src_m = irq_src;

    @(posedge clk);
    #1;
    bus_idle();

    check("rvalid", 32'(bus_if.rvalid), 32'(rd));
    if (rd) check("read_data", bus_if.read_data, exp_rd);
    check("err", 32'(bus_if.err), 32'(exp_err));
    check("tx_write", 32'(tx_write), 32'(exp_tx));
    check("rx_read", 32'(rx_read), 32'(exp_rx));
    check("sr_read", 32'(sr_read), 32'(exp_sr));
    for (int k = 0; k < NCH; k++) begin
      check($sformatf("cr[%0d]", k), cr_p[k], cr_m[k]);
      check($sformatf("tdr[%0d]", k), tdr_p[k], tdr_m[k]);
    end
    check("irq", 32'(irq), 32'(|(ier_m & ipr_m)));
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < NCH; k++) begin
      check({tag, " cr"}, cr_p[k], CR_INIT);
      check({tag, " tdr"}, tdr_p[k], 32'h0);
    end
    check({tag, " read_data"}, bus_if.read_data, 32'h0);
    check({tag, " rvalid"}, 32'(bus_if.rvalid), 32'h0);
    check({tag, " err"}, 32'(bus_if.err), 32'h0);
    check({tag, " irq"}, 32'(irq), 32'h0);
    check({tag, " strobes"}, 32'({tx_write, rx_read, sr_read}), 32'h0);
  endtask

  // Mid-cycle asynchronous reset with requests held active throughout.
  task automatic async_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_rst");
    bus_if.we         = 1'b1;
    bus_if.re         = 1'b1;
    bus_if.addr       = ADDR_W'(6);
    bus_if.be         = 4'hf;
    bus_if.write_data = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_reset_outputs("in_reset");
    end
    bus_idle();
    rst_n = 1'b1;
  endtask

  initial begin
    bus_idle();
    sr_p    = '0;
    rdr_p   = '0;
    irq_src = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Dirty some state, leave strobes/rvalid high, then reset mid-cycle.
    step(1'b1, 1'b0, 4, 4'hf, 32'hdeadbeef);
    step(1'b1, 1'b1, 6, 4'hf, 32'h0badf00d);
    async_reset();
    step(1'b0, 1'b1, 8, 4'h0, 32'h0);
    check("cr2_after_reset", bus_if.read_data, 32'h0000c000);

    // Byte-enabled TDR write
    step(1'b1, 1'b0, 6, 4'b0101, 32'hAABBCCDD);
    check("tdr1_be", tdr_p[1], 32'h00BB00DD);
    check("tx_write_1", 32'(tx_write), 32'h2);
    step(1'b0, 1'b0, 0, 4'h0, 32'h0);

    // Self-clearing reset bits: single write, then back-to-back writes
    step(1'b1, 1'b0, 0, 4'hf, 32'h0000c003);
    check("cr0_set", cr_p[0], 32'h0000c003);
    step(1'b0, 1'b0, 0, 4'h0, 32'h0);
    check("cr0_clr", cr_p[0], 32'h0000c000);
    step(1'b1, 1'b0, 0, 4'hf, 32'h0000c003);
    step(1'b1, 1'b0, 0, 4'hf, 32'h0000c003);
    check("cr0_hold", cr_p[0], 32'h0000c003);
    step(1'b0, 1'b1, 0, 4'h0, 32'h0);
    check("cr0_read_pre", bus_if.read_data, 32'h0000c003);
    check("cr0_clr2", cr_p[0], 32'h0000c000);

    // Interrupt controller
    step(1'b1, 1'b0, NREG, 4'hf, 32'h4);
    irq_src = 4'b0100;
    step(1'b0, 1'b0, 0, 4'h0, 32'h0);
    check("irq_set", 32'(irq), 32'h1);
    step(1'b0, 1'b1, NREG + 1, 4'h0, 32'h0);
    check("ipr_read", bus_if.read_data, 32'h4);
    irq_src = '0;
    step(1'b1, 1'b0, NREG + 1, 4'b0001, 32'h4);
    check("irq_cleared", 32'(irq), 32'h0);
    irq_src = 4'b0100;
    step(1'b1, 1'b0, NREG + 1, 4'b0001, 32'h4);
    check("irq_set_wins", 32'(irq), 32'h1);
    irq_src = '0;

    // Read side effects
    sr_p[3]  = 32'h1;
    rdr_p[3] = 32'h41;
    step(1'b0, 1'b1, 15, 4'h0, 32'h0);
    check("rdr3", bus_if.read_data, 32'h41);
    check("rx_read3", 32'(rx_read), 32'h8);
    step(1'b0, 1'b1, 13, 4'h0, 32'h0);
    check("sr3", bus_if.read_data, 32'h1);
    check("sr_read3", 32'(sr_read), 32'h8);

    // Unmapped and ID
    step(1'b0, 1'b1, NREG + 3, 4'h0, 32'h0);
    check("unmapped_err", 32'(bus_if.err), 32'h1);
    check("unmapped_data", bus_if.read_data, 32'h0);
    step(1'b0, 1'b1, NREG + 2, 4'h0, 32'h0);
    check("id", bus_if.read_data, 32'h55520004);
    check("id_no_err", 32'(bus_if.err), 32'h0);
    step(1'b1, 1'b1, NREG + 5, 4'hf, 32'hffffffff);
    check("unmapped_both_err", 32'(bus_if.err), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      int a;
      a = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, (1 << ADDR_W) - 1))
                                       : int'($urandom_range(0, NREG + 4));
      irq_src = NCH'($urandom);
      for (int k = 0; k < NCH; k++) begin
        sr_p[k]  = $urandom;
        rdr_p[k] = $urandom;
      end
      step(1'($urandom), 1'($urandom), a, 4'($urandom), $urandom);
    end

    async_reset();
    step(1'b0, 1'b1, NREG + 1, 4'h0, 32'h0);
    check("ipr_after_reset", bus_if.read_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_regbank.md
# uart_regbank

Parametrised register bank for the multi-channel UART subsystem. It sits between the processor bus (word address, `we`/`re` strobes) and `NCH` UART channels. Per channel it provides a configuration register, a status register, a transmit-data register and a receive-data register. It adds a registered read path, byte-enabled writes, self-clearing reset bits, an edge-latched interrupt controller and error flagging of unmapped accesses.

## Interface
- `NCH`, 4 — number of UART channels, 1..16.
- `ADDR_W`, 22 — word-address width.
- `CR_INIT`, 32'h0000c000 — reset value of every channel CR.
- `RX_RST_BIT`, 0 — CR bit index of the self-clearing rx_reset.
- `TX_RST_BIT`, 1 — CR bit index of the self-clearing tx_reset.
- `clk` in 1 — the single clock; all state changes on its rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `addr` in `ADDR_W` — word address.
- `we` in 1 — write request, single cycle.
- `re` in 1 — read request, single cycle.
- `be` in 4 — write byte enables; `be[i]` covers `write_data[8i+7:8i]`.
- `write_data` in 32 — write data.
- `read_data` out 32 — registered read data.
- `rvalid` out 1 — `read_data` is valid this cycle.
- `err` out 1 — one-cycle pulse when an access hits an unmapped address.
- `cr` out 32·NCH — channel CRs; channel k occupies bits `[32k+31:32k]`.
- `tdr` out 32·NCH — channel TDRs.
- `sr` in 32·NCH — channel status words.
- `rdr` in 32·NCH — channel receive words.
- `tx_write`, `rx_read`, `sr_read` out NCH each — per-channel one-cycle strobes.
- `irq_src` in NCH — per-channel interrupt source level.
- `irq` out 1 — `|(IER & IPR)`.

## Operation
- **Address map.** For `addr < 4·NCH`: channel `ch = addr>>2`.
  - `addr[1:0]` 0 = CR (RW), 1 = SR (RO), 2 = TDR (RW), 3 = RDR (RO).
  - `4·NCH` = IER (RW, bits `[NCH-1:0]`, upper bits read 0).
  - `4·NCH+1` = IPR (read / write-1-to-clear).
  - `4·NCH+2` = ID (RO, `32'h55520000 | NCH`).
  - Every other address is unmapped.
- **Writes.**
  - The rising edge with `we=1` updates only the bytes enabled by `be`.
  - `be=0` changes nothing but is still a valid access.
  - Writes to SR, RDR and ID are ignored, with no `err` and no strobe.
- **Self-clear.**
  - Any CR reset bit that reads 1 is cleared on the following edge, so it is high for exactly one cycle.
  - If a write in that same cycle sets the bit again, the write wins and the bit stays 1 for one more cycle.
- **Interrupts.**
  - The block registers `irq_src` into `src_d`.
  - The pending bit for channel k sets when `irq_src[k] & ~src_d[k]` (rising edge).
  - Writing 1 to an IPR bit clears it; this honours `be[0]` for bits 7:0 and `be[1]` for bits 15:8.
  - When a set and a clear hit the same bit in the same cycle, the set wins.
  - `irq` is combinational from the IER and IPR flops.
- **Reads.**
  - Data is sampled in the `re` cycle from the current register or input values.
  - With `we` and `re` in the same cycle, the read returns the pre-write value.
  - Unmapped reads return 0.
- **Errors.** `err` pulses in the cycle after an unmapped `we` or `re`. When both are asserted, it pulses once.
- **Strobes.** All strobes are registered and fire in the cycle after the request:
  - `tx_write[ch]` after a write to TDR(ch); the new `tdr` is visible in the same cycle, whatever `be` is.
  - `rx_read[ch]` after a read of RDR(ch), aligned with `rvalid`.
  - `sr_read[ch]` after a read of SR(ch), aligned with `rvalid`.
- **Request rules.**
  - There is no backpressure: one request may be issued every cycle.
  - Back-to-back reads give back-to-back `rvalid`.

## Timing
- **Reset values:**
  - every `cr` = `CR_INIT`;
  - `tdr`, IER, IPR, `src_d` = 0;
  - `read_data` = 0;
  - `rvalid`, `err`, `irq`, and all strobes = 0.
- **Reset behaviour.**
  - Assertion of `rst_n` acts immediately, without waiting for a clock edge.
  - After release, the first edge that samples `rst_n=1` may accept a request.
  - A request in flight during reset is dropped, with no `rvalid` and no strobe.
- **Read latency.** `re` at edge N gives `rvalid`/`read_data` valid for the cycle after edge N, deasserting at edge N+1 unless a new `re` arrives.
- **Write latency.**
  - `we` at edge N makes the register updated and the strobe high after edge N.
  - A self-cleared bit falls at edge N+1.
- **Interrupt latency.** `irq_src` rising before edge N sets IPR at edge N; `irq` is high after edge N if IER is set.

## Test plan
- **Reset.** Assert `rst_n=0` mid-cycle → outputs match the reset values asynchronously; read CR(2) after release → `rvalid` one cycle later with `read_data=32'h0000c000`.
- **Byte-enabled write.** Write TDR(1)=`32'hAABBCCDD` with `be=4'b0101` over `32'h0` → `tdr[63:32]=32'h00BB00DD`; `tx_write=4'b0010` for exactly one cycle, aligned with the new value.
- **Self-clear.**
  - Write CR(0)=`32'h0000c003` → bits 1:0 high for one cycle, then CR reads `32'h0000c000`.
  - Repeat with a back-to-back second write → bits stay high for two cycles.
- **Interrupt controller.**
  - Set IER=`4'b0100`, pulse `irq_src[2]` → IPR=`4'b0100` and `irq=1` after one edge.
  - Write IPR=`4'b0100` → `irq=0`.
  - Raise `irq_src[2]` again in the clearing cycle → IPR stays set.
- **Read side effects.** With `rdr[3]=32'h41` and `sr[3]=32'h1`, read RDR(3) then SR(3) back-to-back → `rvalid` on two consecutive cycles with data `32'h41` then `32'h1`, and `rx_read[3]` / `sr_read[3]` aligned with the respective data.
- **Unmapped and ID.** Read address `4·NCH+3` → `err` and `rvalid` for one cycle with `read_data=0`; read `4·NCH+2` → `32'h55520004` (NCH=4) and no `err`.
